// File: rtl/fifteen_move_scrambler.sv
// 15-puzzle scramble source: emits LFSR-driven legal moves one per handshake, never
// undoing the previous move, and tracks the blank position it has produced so far.
module fifteen_move_scrambler #(
    parameter int unsigned NUM_MOVES = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [1:0]  motion,
    output logic        motion_valid,
    input  logic        motion_ready,
    output logic [3:0]  zero_pos,
    output logic [7:0]  move_count,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0]  MV_UP     = 2'b00;
    localparam logic [1:0]  MV_RIGHT  = 2'b01;
    localparam logic [1:0]  MV_DOWN   = 2'b10;
    localparam logic [1:0]  MV_LEFT   = 2'b11;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [7:0]  MOVES_TOTAL = 8'(NUM_MOVES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] lfsr_r;
    logic [1:0]  motion_r;
    logic        motion_valid_r;
    logic [3:0]  zero_pos_r;
    logic [7:0]  move_count_r;
    logic        busy_r;
    logic        done_r;
    logic [1:0]  last_r;
    logic        has_last_r;

    logic [1:0]  cand0_s;
    logic [1:0]  cand1_s;
    logic [1:0]  cand2_s;
    logic [1:0]  cand3_s;
    logic [1:0]  pick_s;
    logic [7:0]  count_inc_s;
    logic [15:0] seed_val_s;

    // A move is acceptable if it keeps the blank on the board and does not reverse the last one.
    function automatic logic move_ok(input logic [1:0] m, input logic [3:0] pos,
                                     input logic has_last, input logic [1:0] last);
        logic legal;
        case (m)
            MV_UP:    legal = (pos < 4'd12);
            MV_RIGHT: legal = (pos[1:0] != 2'd0);
            MV_DOWN:  legal = (pos >= 4'd4);
            MV_LEFT:  legal = (pos[1:0] != 2'd3);
            default:  legal = 1'b0;
        endcase
        return legal && !(has_last && (m == (last ^ 2'b10)));
    endfunction

    function automatic logic [3:0] next_pos(input logic [1:0] m, input logic [3:0] pos);
        logic [3:0] np;
        case (m)
            MV_UP:    np = pos + 4'd4;
            MV_RIGHT: np = pos - 4'd1;
            MV_DOWN:  np = pos - 4'd4;
            MV_LEFT:  np = pos + 4'd1;
            default:  np = pos;
        endcase
        return np;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Rotating candidate search starting from the LFSR's low bits.
    always_comb begin
        cand0_s = lfsr_r[1:0];
        cand1_s = lfsr_r[1:0] + 2'd1;
        cand2_s = lfsr_r[1:0] + 2'd2;
        cand3_s = lfsr_r[1:0] + 2'd3;
        if (move_ok(cand0_s, zero_pos_r, has_last_r, last_r)) begin
            pick_s = cand0_s;
        end else if (move_ok(cand1_s, zero_pos_r, has_last_r, last_r)) begin
            pick_s = cand1_s;
        end else if (move_ok(cand2_s, zero_pos_r, has_last_r, last_r)) begin
            pick_s = cand2_s;
        end else begin
            pick_s = cand3_s;
        end
        count_inc_s = move_count_r + 8'd1;
        if (seed == 16'h0000) begin
            seed_val_s = LFSR_SEED;
        end else begin
            seed_val_s = seed;
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            lfsr_r         <= LFSR_SEED;
            motion_r       <= 2'b00;
            motion_valid_r <= 1'b0;
            zero_pos_r     <= 4'd0;
            move_count_r   <= 8'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            last_r         <= 2'b00;
            has_last_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (seed_load) begin
                        lfsr_r <= seed_val_s;
                    end else if (start) begin
                        zero_pos_r   <= 4'd0;
                        move_count_r <= 8'd0;
                        has_last_r   <= 1'b0;
                        if (MOVES_TOTAL == 8'd0) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_STEP;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    motion_r       <= pick_s;
                    motion_valid_r <= 1'b1;
                    lfsr_r         <= lfsr_step(lfsr_r);
                    state_r        <= ST_SEND;
                end
                ST_SEND: begin
                    if (motion_ready) begin
                        zero_pos_r     <= next_pos(motion_r, zero_pos_r);
                        last_r         <= motion_r;
                        has_last_r     <= 1'b1;
                        move_count_r   <= count_inc_s;
                        motion_valid_r <= 1'b0;
                        if (count_inc_s == MOVES_TOTAL) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_STEP;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    motion_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                    done_r         <= 1'b0;
                end
            endcase
        end
    end

    assign motion       = motion_r;
    assign motion_valid = motion_valid_r;
    assign zero_pos     = zero_pos_r;
    assign move_count   = move_count_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_fifteen_move_scrambler.sv
// Bench for fifteen_move_scrambler: three instances (16, 200 and 0 moves) share stimulus
// and are checked every cycle against a transaction-level model of the scramble rules.
module tb_fifteen_move_scrambler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        seed_load;
    logic [15:0] seed;
    logic        motion_ready;
    logic [1:0]  mo [3];
    logic        mv [3];
    logic [3:0]  zp [3];
    logic [7:0]  mc [3];
    logic        bz [3];
    logic        dn [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifteen_move_scrambler #(.NUM_MOVES(16), .LFSR_SEED(16'hACE1)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed(seed),
        .motion(mo[0]), .motion_valid(mv[0]), .motion_ready(motion_ready),
        .zero_pos(zp[0]), .move_count(mc[0]), .busy(bz[0]), .done(dn[0]));

    fifteen_move_scrambler #(.NUM_MOVES(200), .LFSR_SEED(16'hACE1)) u_dut200 (
        .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed(seed),
        .motion(mo[1]), .motion_valid(mv[1]), .motion_ready(motion_ready),
        .zero_pos(zp[1]), .move_count(mc[1]), .busy(bz[1]), .done(dn[1]));

    fifteen_move_scrambler #(.NUM_MOVES(0), .LFSR_SEED(16'hACE1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed(seed),
        .motion(mo[2]), .motion_valid(mv[2]), .motion_ready(motion_ready),
        .zero_pos(zp[2]), .move_count(mc[2]), .busy(bz[2]), .done(dn[2]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [1:0] m, input int pos);
        case (m)
            2'b00:   return pos < 12;
            2'b01:   return (pos % 4) != 0;
            2'b10:   return pos >= 4;
            default: return (pos % 4) != 3;
        endcase
    endfunction

    function automatic int delta(input logic [1:0] m);
        case (m)
            2'b00:   return 4;
            2'b01:   return -1;
            2'b10:   return -4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [1:0] pick_move(input logic [15:0] l, input int pos,
                                             input bit hl, input logic [1:0] last);
        logic [1:0] m;
        for (int k = 0; k < 4; k++) begin
            m = l[1:0] + 2'(k);
            if (is_legal(m, pos) && !(hl && m == (last ^ 2'b10))) return m;
        end
        return 2'b00;
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // model state per instance
    int          nms [3] = '{16, 200, 0};
    logic [15:0] m_lfsr [3];
    int          m_pos [3];
    int          m_cnt [3];
    bit          m_busy [3];
    bit          m_step [3];
    bit          m_done [3];
    bit          m_hl [3];
    logic [1:0]  m_last [3];
    bit          hold_prev [3];
    logic [1:0]  prev_mo [3];
    logic [1:0]  exp_mv;
    bit          mon_en = 1'b0;
    logic [1:0]  hist0 [$];

    // Compare every instance against the model, then advance the model over the coming edge.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            exp_mv = pick_move(m_lfsr[g], m_pos[g], m_hl[g], m_last[g]);
            if (mon_en) begin
                check($sformatf("zero_pos[%0d]", g), 32'(zp[g]), 32'(m_pos[g]));
                check($sformatf("move_count[%0d]", g), 32'(mc[g]), 32'(m_cnt[g]));
                check($sformatf("busy[%0d]", g), 32'(bz[g]), 32'(m_busy[g]));
                check($sformatf("done[%0d]", g), 32'(dn[g]), 32'(m_done[g]));
                check($sformatf("valid[%0d]", g), 32'(mv[g]), 32'(m_busy[g] && !m_step[g]));
                if (m_busy[g] && !m_step[g]) begin
                    check($sformatf("motion[%0d]", g), 32'(mo[g]), 32'(exp_mv));
                    check($sformatf("legal[%0d]", g), 32'(is_legal(mo[g], m_pos[g])), 32'd1);
                    check($sformatf("no_undo[%0d]", g),
                          32'(m_hl[g] && (mo[g] == (m_last[g] ^ 2'b10))), 32'd0);
                end
                if (hold_prev[g]) begin
                    check($sformatf("hold_motion[%0d]", g), 32'(mo[g]), 32'(prev_mo[g]));
                end
            end
            hold_prev[g] = mv[g] && !motion_ready && !rst && mon_en;
            prev_mo[g] = mo[g];
            if (rst) begin
                m_lfsr[g] = 16'hACE1;
                m_pos[g] = 0; m_cnt[g] = 0;
                m_busy[g] = 1'b0; m_step[g] = 1'b0; m_done[g] = 1'b0; m_hl[g] = 1'b0;
                m_last[g] = 2'b00;
            end else if (m_done[g]) begin
                m_done[g] = 1'b0;
            end else if (!m_busy[g]) begin
                if (seed_load) begin
                    m_lfsr[g] = (seed == 16'h0000) ? 16'hACE1 : seed;
                end else if (start) begin
                    m_pos[g] = 0; m_cnt[g] = 0; m_hl[g] = 1'b0;
                    if (nms[g] == 0) begin
                        m_done[g] = 1'b1;
                    end else begin
                        m_busy[g] = 1'b1;
                        m_step[g] = 1'b1;
                    end
                end
            end else if (m_step[g]) begin
                m_step[g] = 1'b0;
            end else if (motion_ready) begin
                if (g == 0) hist0.push_back(mo[0]);
                m_pos[g] = m_pos[g] + delta(exp_mv);
                m_last[g] = exp_mv;
                m_hl[g] = 1'b1;
                m_cnt[g] = m_cnt[g] + 1;
                m_lfsr[g] = lfsr_adv(m_lfsr[g]);
                if (m_cnt[g] == nms[g]) begin
                    m_busy[g] = 1'b0;
                    m_done[g] = 1'b1;
                end else begin
                    m_step[g] = 1'b1;
                end
            end
        end
        if (rst) mon_en = 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done1(input int lim);
        int k = 0;
        while (!dn[1] && k < lim) begin
            tick();
            k++;
        end
        check("done200_seen", 32'(dn[1]), 32'd1);
        tick();
    endtask

    logic [1:0] seq_a [$];
    logic [1:0] m0;
    int tile [16];
    int blank;
    int pulses;
    bit solved;

    task automatic apply_move(input logic [1:0] m);
        int np;
        np = blank + delta(m);
        tile[blank] = tile[np];
        tile[np] = 0;
        blank = np;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed = 16'h0000; motion_ready = 1'b1;
        repeat (3) tick();
        check("rst_motion", 32'(mo[0]), 32'd0);
        check("rst_valid", 32'(mv[0]), 32'd0);
        check("rst_zero_pos", 32'(zp[0]), 32'd0);
        check("rst_count", 32'(mc[0]), 32'd0);
        check("rst_busy", 32'(bz[0]), 32'd0);
        check("rst_done", 32'(dn[0]), 32'd0);
        rst = 1'b0;
        tick();

        // reset-seed scramble with free-flowing consumer
        hist0.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_step_valid", 32'(mv[0]), 32'd0);
        check("lat_step_busy", 32'(bz[0]), 32'd1);
        check("zero_moves_done", 32'(dn[2]), 32'd1);
        tick();
        check("first_valid", 32'(mv[0]), 32'd1);
        check("first_motion", 32'(mo[0]), 32'd3);
        tick();
        check("first_zero_pos", 32'(zp[0]), 32'd1);
        check("first_count", 32'(mc[0]), 32'd1);
        wait_done1(1000);
        check("seq_a_len", 32'(hist0.size()), 32'd16);
        seq_a = hist0;

        // explicit seed 4 starts with UP
        seed = 16'h0004; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("seed4_motion", 32'(mo[0]), 32'd0);
        tick();
        check("seed4_zero_pos", 32'(zp[0]), 32'd4);
        wait_done1(1000);

        // zero seed reproduces the reset sequence; backpressure on the first move
        seed = 16'h0000; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; hist0.delete(); start = 1'b1;
        tick();
        start = 1'b0; motion_ready = 1'b0;
        tick();
        m0 = mo[0];
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_motion", 32'(mo[0]), 32'(m0));
            check("bp_valid", 32'(mv[0]), 32'd1);
            check("bp_count", 32'(mc[0]), 32'd0);
        end
        motion_ready = 1'b1;
        tick();
        check("bp_accept_count", 32'(mc[0]), 32'd1);
        motion_ready = 1'b0;
        tick();
        tick();
        check("bp_single_count", 32'(mc[0]), 32'd1);
        check("bp_next_valid", 32'(mv[0]), 32'd1);
        motion_ready = 1'b1;
        wait_done1(1000);
        check("seq_c_len", 32'(hist0.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < hist0.size() && i < seq_a.size())
                check($sformatf("seed0_seq[%0d]", i), 32'(hist0[i]), 32'(seq_a[i]));
        end

        // puzzle replay forward then inverse in reverse order
        for (int i = 0; i < 16; i++) tile[i] = i;
        blank = 0;
        for (int i = 0; i < hist0.size(); i++) apply_move(hist0[i]);
        check("replay_blank", 32'(blank), 32'(zp[0]));
        for (int i = hist0.size() - 1; i >= 0; i--) apply_move(hist0[i] ^ 2'b10);
        solved = 1'b1;
        for (int i = 0; i < 16; i++) if (tile[i] != i) solved = 1'b0;
        check("replay_solved", 32'(solved), 32'd1);

        // 200 moves with random consumer stalls
        pulses = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3000 && pulses == 0; k++) begin
            motion_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (dn[1]) begin
                pulses++;
                check("done200_count", 32'(mc[1]), 32'd200);
            end
        end
        motion_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (dn[1]) pulses++;
        end
        check("done200_pulses", 32'(pulses), 32'd1);

        // reset during SEND with start held high throughout
        motion_ready = 1'b0; start = 1'b1;
        for (int k = 0; k < 10 && !mv[0]; k++) tick();
        check("pre_rst_valid", 32'(mv[0]), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_send_valid", 32'(mv[0]), 32'd0);
        check("rst_send_zero_pos", 32'(zp[0]), 32'd0);
        check("rst_send_busy", 32'(bz[0]), 32'd0);
        rst = 1'b0;
        tick();
        check("restart_busy", 32'(bz[0]), 32'd1);
        tick();
        check("restart_motion", 32'(mo[0]), 32'd3);
        motion_ready = 1'b1;
        repeat (60) tick();
        start = 1'b0;
        wait_done1(1000);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
